uart_recv: RTL and testbench
============================

// Module: uart_recv
// PURPOSE
//  8N1 UART receiver, the downstream partner of uart_trans on the UART_VGA path.
//  Samples the asynchronous serial line at mid-bit and deserialises LSB-first data.
//  Presents each good byte with a one-cycle valid strobe and flags bad stop bits.
//  Line idles high. Default rate is 9600 baud from a 100 MHz clk, matching uart_trans.
// PARAMETERS
//  CLKS_PER_BIT  10417  clk cycles per bit period; must be >= 4. HALF = CLKS_PER_BIT/2 (integer).
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  serial_in   in   1  asynchronous UART line, idle high
//  data_out    out  8  last correctly received byte; held until the next good byte
//  valid       out  1  one-cycle strobe: data_out has just been updated
//  frame_err   out  1  one-cycle strobe: stop bit was sampled low
//  busy        out  1  high whenever the state is not IDLE
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (rst_n).
//   - On assertion, immediately: data_out=0, valid=0, frame_err=0, busy=0, state=IDLE.
//   - Bit counter and clock counter are cleared. The synchroniser flops are preset to 1.
//   - Reset mid-frame abandons the frame. No strobe is produced for that frame.
//  Input: 2-FF synchroniser, reset to 1. All decisions use the synchronised bit (rx_s).
//  Clock counter: width $clog2(CLKS_PER_BIT); cleared on every state entry.
//  States:
//   IDLE  : rx_s==0 -> START.
//   START : when cnt==HALF-1, sample rx_s.
//           - rx_s==1 -> IDLE (glitch rejected, no strobe).
//           - rx_s==0 -> DATA with bit index=0.
//   DATA  : when cnt==CLKS_PER_BIT-1, shift rx_s into shift_reg[bit index] (LSB first).
//           - bit index 7 -> STOP; otherwise bit index increments.
//   STOP  : when cnt==CLKS_PER_BIT-1, sample rx_s.
//           - rx_s==1 -> data_out<=shift_reg, valid=1 for one cycle, -> IDLE.
//           - rx_s==0 -> frame_err=1 for one cycle, data_out unchanged, -> BREAK.
//   BREAK : stay until rx_s==1, then -> IDLE.
//           - A held-low line (break) yields exactly one frame_err.
//  Timing: t0 = the cycle IDLE sees rx_s==0.
//   - Start sample at t0+HALF.
//   - Data bit k sampled at t0+HALF+(k+1)*CLKS_PER_BIT.
//   - Stop sample at t0+HALF+9*CLKS_PER_BIT.
//   - valid/frame_err are registered and high on the next cycle only.
//   - Total latency from line falling edge = 2 (sync) + HALF + 9*CLKS_PER_BIT + 1 cycles.
//  Back-to-back frames: IDLE is re-entered at mid-stop-bit.
//   - A start edge arriving one stop bit after the previous start+8 data bits is caught.
//  valid and frame_err are never high together. Neither is high outside the cycle after STOP.
//  No receive buffering: a consumer must take data_out within 1 frame time after valid.
//   - data_out is held until the next good byte.
// TESTING
//  Run with CLKS_PER_BIT=16 for speed; repeat test 1 at 10417.
//  1. Loopback from uart_trans, send 0x61
//     -> data_out=0x61, valid high 1 cycle at the latency above, frame_err=0.
//  2. Back-to-back 0x00, 0xFF, 0xA5, one stop bit each, no idle gap
//     -> three valid strobes in order with matching data_out, no frame_err.
//  3. Line low for 4 cycles then high (glitch)
//     -> busy pulses, returns to IDLE, no valid and no frame_err.
//  4. Send 0x3C with stop bit forced low, then hold line low 3 bit times, then release and send 0x55
//     -> one frame_err, data_out keeps its prior value, no start until line goes high,
//        then valid with data_out=0x55.
//  5. Assert rst_n during DATA bit 4
//     -> all outputs 0 immediately.
//     Release with line idle, then send 0xC3 -> valid with data_out=0xC3.
//  6. Transmitter bit period +3% and -3% of CLKS_PER_BIT, send 0x96
//     -> data_out=0x96, valid, no frame_err.

Source files
------------

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with mid-bit sampling, LSB first.
// Good bytes strobe valid; a low stop bit strobes frame_err.
module uart_recv #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // Two-flop synchroniser; preset high so reset looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM: start qualification, data shift, stop check, break wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out <= shift_reg;
                            valid    <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: randomized scoreboard bench for uart_recv.
// Frames are driven at the line level; strobes are checked by a monitor.
module tb_uart_recv;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam longint LAT = 3 + HALF + 9 * CPB;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        longint     due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    exp_t       sb[$];
    exp_t       mon_e;
    longint     cyc;
    int         checks;
    int         errors;
    logic [7:0] last_good;
    bit         busy_seen;

    uart_recv #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        tick(n);
    endtask

    // pct scales the bit period; abort_at>0 cuts the frame short, no response
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int pct, input int abort_at);
        logic [9:0] bits;
        int         len;
        exp_t       e;
        bits = {stop_ok, d, 1'b0};
        len  = 10 * CPB * pct / 100;
        if (abort_at > 0) begin
            len = abort_at;
        end else begin
            e.ferr = !stop_ok;
            e.data = d;
            e.due  = cyc + LAT;
            sb.push_back(e);
        end
        for (int off = 0; off < len; off++) begin
            serial_in = bits[off * 100 / (CPB * pct)];
            tick(1);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40 * CPB) begin
            tick(1);
            n++;
        end
        tick(4);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every strobe must match the oldest outstanding frame
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (rst_n && (valid || frame_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=0x%0h cycle %0d",
                         valid, frame_err, data_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("exclusive", longint'(valid && frame_err), 0);
                chk("kind_ferr", longint'(frame_err), longint'(mon_e.ferr));
                chk("latency", cyc, mon_e.due);
                if (mon_e.ferr) begin
                    chk("data_hold", data_out, last_good);
                end else begin
                    chk("data", data_out, mon_e.data);
                    last_good = mon_e.data;
                end
            end
        end
    end

    initial begin
        int   pct;
        bit   ok;
        logic [7:0] d;
        int   gap;
        checks    = 0;
        errors    = 0;
        last_good = 8'h00;
        busy_seen = 1'b0;
        rst_n     = 1'b0;
        serial_in = 1'b1;
        tick(3);
        chk("rst_data", data_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(2 * CPB);

        // single frame, nominal rate
        send_frame(8'h61, 1'b1, 100, 0);
        idle(CPB);
        drain("t1_drain");
        chk("t1_data", data_out, 8'h61);

        // back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 100, 0);
        send_frame(8'hFF, 1'b1, 100, 0);
        send_frame(8'hA5, 1'b1, 100, 0);
        idle(CPB);
        drain("t2_drain");

        // short glitch must be rejected
        busy_seen = 1'b0;
        serial_in = 1'b0;
        tick(4);
        idle(2 * CPB);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_idle", busy, 0);
        chk("glitch_data", data_out, last_good);

        // bad stop bit, held break, then a good frame
        send_frame(8'h3C, 1'b0, 100, 0);
        tick(3 * CPB);
        chk("break_busy", busy, 1);
        chk("break_data", data_out, 8'hA5);
        idle(4);
        chk("break_exit", busy, 0);
        idle(2 * CPB);
        send_frame(8'h55, 1'b1, 100, 0);
        idle(CPB);
        drain("t4_drain");
        chk("t4_data", data_out, 8'h55);

        // reset in the middle of data bit 4
        send_frame(8'hA7, 1'b1, 100, 80);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", data_out, 0);
        chk("arst_valid", valid, 0);
        chk("arst_ferr", frame_err, 0);
        chk("arst_busy", busy, 0);
        last_good = 8'h00;
        serial_in = 1'b1;
        tick(3);
        rst_n = 1'b1;
        idle(CPB);
        send_frame(8'hC3, 1'b1, 100, 0);
        idle(CPB);
        drain("t5_drain");
        chk("t5_data", data_out, 8'hC3);

        // transmitter clock skew of +3% and -3%
        send_frame(8'h96, 1'b1, 103, 0);
        idle(CPB);
        send_frame(8'h96, 1'b1, 97, 0);
        idle(CPB);
        drain("t6_drain");

        // random traffic: skewed rates, occasional bad stop bits
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 4) != 0);
            pct = ($urandom_range(0, 2) == 0) ? 97 :
                  (($urandom_range(0, 1) == 0) ? 100 : 103);
            send_frame(d, ok, pct, 0);
            gap = ok ? $urandom_range(0, CPB) : $urandom_range(2, 2 * CPB);
            if (gap > 0) idle(gap);
        end
        idle(CPB);
        drain("rand_drain");

        chk("final_data", data_out, last_good);
        chk("final_idle", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
